// File: rtl/accel_arbiter.sv
// Two-requester round-robin front end for a single accelerator core.
// Grants one job at a time, starts the core, waits for done or timeout, and holds the response until it is read.
module accel_arbiter #(
    parameter int DATA_W  = 1024,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_din,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_din,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_dout,
    output logic              rsp_err,
    input  logic              rsp_read,
    output logic              accel_start,
    output logic [DATA_W-1:0] accel_din,
    input  logic [DATA_W-1:0] accel_dout,
    input  logic              accel_done,
    output logic              busy
);

    // Counter only ever reaches TIMEOUT-1 before the timeout exit.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    logic                last_id;
    logic [DATA_W-1:0]   operand;
    logic [CNT_W-1:0]    wait_cnt;
    logic                grant0;
    logic                grant1;

    // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_id);
            grant1 = req1_valid && (!req0_valid || !last_id);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accel_din  = operand;

    // NOTE: all state below is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_id     <= 1'b1;
            operand     <= '0;
            rsp_dout    <= '0;
            rsp_id      <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b0;
            wait_cnt    <= '0;
            accel_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        operand     <= grant1 ? req1_din : req0_din;
                        rsp_id      <= grant1;
                        last_id     <= grant1;
                        accel_start <= 1'b1;
                        busy        <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    accel_start <= 1'b0;
                    wait_cnt    <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still counts as a normal completion.
                    if (accel_done) begin
                        rsp_dout  <= accel_dout;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_dout  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_read) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_arbiter.sv
// Directed bench for accel_arbiter with a delayed-increment core model and a response scoreboard.
module tb_accel_arbiter;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_din, req1_din;
    logic          req0_ready, req1_ready;
    logic          rsp_valid, rsp_id, rsp_err, rsp_read;
    logic [DW-1:0] rsp_dout;
    logic          accel_start, accel_done, busy;
    logic [DW-1:0] accel_din, accel_dout;

    logic          core_done, force_done;
    logic [DW-1:0] core_din, core_dout;
    int            core_cnt;
    int            core_delay;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] dout;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    accel_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_din   (req0_din),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_din   (req1_din),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_dout   (rsp_dout),
        .rsp_err    (rsp_err),
        .rsp_read   (rsp_read),
        .accel_start(accel_start),
        .accel_din  (accel_din),
        .accel_dout (accel_dout),
        .accel_done (accel_done),
        .busy       (busy)
    );

    assign accel_done = core_done | force_done;
    assign accel_dout = core_dout;

    // Core model: done (with din+1) during the core_delay-th cycle after the start cycle; delay 0 never finishes.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (reset) begin
            core_cnt <= 0;
        end else if (accel_start && core_delay >= 2) begin
            core_cnt <= core_delay - 1;
            core_din <= accel_din;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_done <= 1'b1;
                core_dout <= core_din + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for rsp_valid, reports cycles waited, and compares against the scoreboard head.
    task automatic wait_rsp(input int max_cyc, output int n);
        rsp_t e;
        n = 0;
        while (!rsp_valid && n < max_cyc) begin
            tick();
            n++;
        end
        check("rsp_arrived", rsp_valid, 1);
        check("sb_nonempty", sb.size() > 0, 1);
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_dout", rsp_dout, e.dout);
            check("rsp_err", rsp_err, e.err);
        end
    endtask

    task automatic read_rsp();
        rsp_read = 1'b1;
        tick();
        rsp_read = 1'b0;
        check("rsp_cleared", rsp_valid, 0);
        check("idle_after_read", busy, 0);
    endtask

    initial begin
        int n;
        int got_id;
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_din = '0; req1_din = '0; rsp_read = 1'b0;
        force_done = 1'b0; core_delay = 10;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_start", accel_start, 0);
        check("rst_rsp_dout", rsp_dout, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_operand", accel_din, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        reset = 1'b0;

        // Single request from requester 0, core answers din+1 after 10 cycles.
        req0_valid = 1'b1; req0_din = 5;
        #1;
        check("c1_ready0", req0_ready, 1);
        check("c1_ready1", req1_ready, 0);
        sb.push_back('{id: 1'b0, dout: 32'd6, err: 1'b0});
        tick();
        req0_valid = 1'b0;
        check("c1_start", accel_start, 1);
        check("c1_ready0_pulse", req0_ready, 0);
        check("c1_busy", busy, 1);
        check("c1_accel_din", accel_din, 5);
        tick();
        check("c1_start_pulse", accel_start, 0);
        wait_rsp(40, n);
        read_rsp();

        // Core never finishes: timeout response 17 cycles after the start cycle, late done ignored.
        core_delay = 0;
        req0_valid = 1'b1; req0_din = 32'h55;
        #1;
        check("c3_ready0", req0_ready, 1);
        sb.push_back('{id: 1'b0, dout: '0, err: 1'b1});
        tick();
        req0_valid = 1'b0;
        check("c3_start", accel_start, 1);
        wait_rsp(40, n);
        check("c3_latency", n, 17);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("c3_late_valid", rsp_valid, 1);
        check("c3_late_err", rsp_err, 1);
        check("c3_late_dout", rsp_dout, 0);
        read_rsp();

        // Done on the 16th WAIT cycle coincides with the timeout and must win.
        core_delay = 16;
        req1_valid = 1'b1; req1_din = 100;
        #1;
        check("c4_ready1", req1_ready, 1);
        sb.push_back('{id: 1'b1, dout: 32'd101, err: 1'b0});
        tick();
        req1_valid = 1'b0;
        wait_rsp(40, n);
        check("c4_latency", n, 17);
        read_rsp();

        // Response held unread for 20 cycles while requester 1 is waiting.
        core_delay = 3;
        req0_valid = 1'b1; req0_din = 7;
        #1;
        check("c5_ready0", req0_ready, 1);
        sb.push_back('{id: 1'b0, dout: 32'd8, err: 1'b0});
        tick();
        req0_valid = 1'b0;
        wait_rsp(40, n);
        req1_valid = 1'b1; req1_din = 9;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("c5_hold_valid", rsp_valid, 1);
            check("c5_hold_dout", rsp_dout, 8);
            check("c5_hold_id", rsp_id, 0);
            check("c5_hold_ready1", req1_ready, 0);
            check("c5_hold_start", accel_start, 0);
        end
        rsp_read = 1'b1;
        tick();
        rsp_read = 1'b0;
        check("c5_ready1_after_read", req1_ready, 1);
        sb.push_back('{id: 1'b1, dout: 32'd10, err: 1'b0});
        tick();
        req1_valid = 1'b0;
        check("c5_start", accel_start, 1);
        wait_rsp(40, n);
        read_rsp();

        // Both requesters held high from reset: grants alternate 0,1,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        core_delay = 2;
        req0_valid = 1'b1; req0_din = 20;
        req1_valid = 1'b1; req1_din = 40;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 50) begin
                tick();
                n++;
            end
            check("rr_grant_seen", req0_ready | req1_ready, 1);
            check("rr_single", req0_ready & req1_ready, 0);
            check("rr_order", req1_ready, k % 2);
            got_id = (k % 2);
            sb.push_back('{id: got_id[0], dout: (got_id == 1) ? 32'd41 : 32'd21, err: 1'b0});
            tick();
            check("rr_pulse0", req0_ready, 0);
            check("rr_pulse1", req1_ready, 0);
            check("rr_start", accel_start, 1);
            wait_rsp(40, n);
            rsp_read = 1'b1;
            tick();
            rsp_read = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Reset in the middle of WAIT abandons the job; a following tie goes to requester 0.
        core_delay = 0;
        req1_valid = 1'b1; req1_din = 77;
        #1;
        check("c6_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        check("c6_in_wait", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("c6_busy", busy, 0);
        check("c6_rsp_valid", rsp_valid, 0);
        check("c6_start", accel_start, 0);
        core_delay = 2;
        req0_valid = 1'b1; req0_din = 3;
        req1_valid = 1'b1; req1_din = 4;
        #1;
        check("c6_tie_ready0", req0_ready, 1);
        check("c6_tie_ready1", req1_ready, 0);
        sb.push_back('{id: 1'b0, dout: 32'd4, err: 1'b0});
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(40, n);
        read_rsp();
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
